// File: rtl/nano_pkg.sv
// Shared types and defaults for the NanoRisc data-memory arbiter.
package nano_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} arb_state_e;
  typedef enum logic {REQ_CORE = 1'b0, REQ_HOST = 1'b1} req_id_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/nano_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not win last time wins.
module nano_rr_pick2
  import nano_pkg::*;
(
  input  logic [1:0] req,         // bit0 = core, bit1 = host
  input  req_id_e    last_grant,
  output req_id_e    winner,
  output logic       any
);
  always_comb begin
    any    = |req;
    winner = REQ_CORE;
    if (req == 2'b11)
      winner = (last_grant == REQ_HOST) ? REQ_CORE : REQ_HOST;
    else if (req[1])
      winner = REQ_HOST;
  end
endmodule

// File: rtl/nano_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between core and host.
// Optional NANO_DMEM_ARB_STATS_EN adds a saturating conflict_count output.
module nano_dmem_arbiter
  import nano_pkg::*;
#(
  parameter int ADDR_W = nano_pkg::ADDR_W,
  parameter int DATA_W = nano_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef NANO_DMEM_ARB_STATS_EN
  output logic [7:0]        conflict_count,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        state_q, state_d;
  req_id_e           owner_q, owner_d;
  req_id_e           last_grant_q, last_grant_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  req_id_e           winner;
  logic              any_req;

  nano_rr_pick2 u_pick (
    .req        ({host_req, core_req}),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any        (any_req)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    core_rdata_d = core_rdata_q;
    host_rdata_d = host_rdata_q;
    core_ready   = 1'b0;
    host_ready   = 1'b0;
    core_rvalid  = 1'b0;
    host_rvalid  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: if (any_req) begin
          mem_en       = 1'b1;
          last_grant_d = winner;
          if (winner == REQ_CORE) begin
            core_ready = 1'b1;
            mem_we     = core_we;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
          end else begin
            host_ready = 1'b1;
            mem_we     = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
          end
          if (!mem_we) begin
            state_d = RD_WAIT;
            owner_d = winner;
          end
        end
        RD_WAIT: begin
          // Memory data is registered, so the read returns the cycle after accept.
          state_d = IDLE;
          if (owner_q == REQ_CORE) begin
            core_rvalid  = 1'b1;
            core_rdata_d = mem_rdata;
          end else begin
            host_rvalid  = 1'b1;
            host_rdata_d = mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    core_rdata = core_rvalid ? mem_rdata : core_rdata_q;
    host_rdata = host_rvalid ? mem_rdata : host_rdata_q;
    core_stall = (core_req & ~core_ready & ~reset) | (core_ready & ~core_we);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CORE;
      last_grant_q <= REQ_HOST;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

`ifdef NANO_DMEM_ARB_STATS_EN
  logic [7:0] conflict_count_q, conflict_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (state_q == IDLE && core_req && host_req)
      conflict_count_d = sat_inc8(conflict_count_q);
  end

  always_ff @(posedge clock) begin
    if (reset) conflict_count_q <= '0;
    else       conflict_count_q <= conflict_count_d;
  end

  assign conflict_count = conflict_count_q;
`endif
endmodule
